// File: rtl/cpu_sd2_pkg.sv
// Shared definitions for the operand-memory stage and operand_alu:
// tx command codes, ALU op encodings and the operand_alu FSM states.
package cpu_sd2_pkg;

  localparam logic [3:0] CLEAR = 4'd0;
  localparam logic [3:0] LOAD  = 4'd1;
  localparam logic [3:0] HOLD  = 4'd2;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_AND    = 2'b10,
    OP_OR_MUL = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_B = 2'd1,
    ST_EXEC   = 2'd2
  } state_e;

endpackage

// File: rtl/operand_alu_alu_core.sv
// Combinational ALU for operand_alu: (a, b, op) -> (res, neg).
// Build option ALU_MUL_EN turns op 11 into an unsigned multiply instead of OR.
module alu_core
  import cpu_sd2_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int RES_W  = 2 * DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [RES_W-1:0]  res,
  output logic              neg
);

  always_comb begin
    res = '0;
    neg = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: res = RES_W'(a) + RES_W'(b);
      // Zero-extended subtraction at RES_W width yields the sign-extended difference.
      OP_SUB: begin
        res = RES_W'(a) - RES_W'(b);
        neg = (a < b);
      end
      OP_AND: res = RES_W'(a & b);
      OP_OR_MUL: begin
`ifdef ALU_MUL_EN
        res = RES_W'(a) * RES_W'(b);
`else
        res = RES_W'(a | b);
`endif
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/operand_alu.sv
// Captures operands A then B from the operand-memory stage, runs one ALU op and
// registers the result with a one-cycle valid pulse. Op 11 depends on ALU_MUL_EN.
module operand_alu
  import cpu_sd2_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int RES_W  = 2 * DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [3:0]        tx,
  input  logic [DATA_W-1:0] entrada,
  input  logic              contador,
  input  logic [1:0]        op,
  output logic [RES_W-1:0]  result,
  output logic              result_valid,
  output logic              neg,
  output logic              busy
);

  state_e              r_state;
  state_e              w_state_next;
  logic [3:0]          r_tx_q;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [1:0]          r_op;
  logic [RES_W-1:0]    r_result;
  logic                r_valid;
  logic                r_neg;

  logic                w_cap_a;
  logic                w_cap_b;
  logic                w_exec;
  logic                w_clear;
  logic [RES_W-1:0]    w_res;
  logic                w_neg;

  alu_core #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) u_alu_core (
    .a   (r_a),
    .b   (r_b),
    .op  (r_op),
    .res (w_res),
    .neg (w_neg)
  );

  // The memory stage updates entrada on the tx==LOAD edge, so act on tx one cycle late.
  always_comb begin
    w_state_next = r_state;
    w_cap_a      = 1'b0;
    w_cap_b      = 1'b0;
    w_exec       = 1'b0;
    w_clear      = 1'b0;
    if (r_tx_q == CLEAR) begin
      w_clear      = 1'b1;
      w_state_next = ST_IDLE;
    end else if (r_tx_q != HOLD) begin
      case (r_state)
        ST_IDLE: begin
          if (r_tx_q == LOAD && contador) begin
            w_cap_a      = 1'b1;
            w_state_next = ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (r_tx_q == LOAD) begin
            if (contador) begin
              w_cap_a = 1'b1;
            end else begin
              w_cap_b      = 1'b1;
              w_state_next = ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          w_exec       = 1'b1;
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_tx_q   <= CLEAR;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      r_tx_q  <= tx;
      r_state <= w_state_next;
      r_valid <= w_exec;
      if (w_clear) begin
        r_a  <= '0;
        r_b  <= '0;
        r_op <= '0;
      end
      if (w_cap_a) begin
        r_a <= entrada;
      end
      if (w_cap_b) begin
        r_b  <= entrada;
        r_op <= op;
      end
      if (w_exec) begin
        r_result <= w_res;
        r_neg    <= w_neg;
      end
    end
  end

  assign result       = r_result;
  assign result_valid = r_valid;
  assign neg          = r_neg;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_operand_alu.sv
// Self-checking bench for operand_alu: a behavioural memory-stage model feeds operand
// pairs; directed table vectors, CLEAR/reset corner cases and random pairs are checked.
module tb_operand_alu;

  localparam logic [3:0] TX_CLEAR = 4'd0;
  localparam logic [3:0] TX_LOAD  = 4'd1;
  localparam logic [3:0] TX_HOLD  = 4'd2;
  localparam logic [3:0] TX_NOP   = 4'd3;

  logic       clock;
  logic       reset_n;
  logic [3:0] tx;
  logic [3:0] entrada;
  logic       contador;
  logic [1:0] op;
  logic [7:0] result;
  logic       result_valid;
  logic       neg;
  logic       busy;

  logic [3:0] src_a;
  logic [3:0] src_b;

  int errors;
  int checks;

  operand_alu #(.DATA_W(4), .RES_W(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tx           (tx),
    .entrada      (entrada),
    .contador     (contador),
    .op           (op),
    .result       (result),
    .result_valid (result_valid),
    .neg          (neg),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory stage: first LOAD presents in1 (contador->1), second presents in2 (contador->0).
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contador <= 1'b0;
      entrada  <= 4'd0;
    end else if (tx == TX_CLEAR) begin
      contador <= 1'b0;
    end else if (tx == TX_LOAD) begin
      contador <= ~contador;
      entrada  <= contador ? src_b : src_a;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic void ref_alu(input int a, input int b, input int o,
                                  output logic [7:0] r, output logic n);
    int v;
    case (o)
      0: v = a + b;
      1: v = a - b;
      2: v = a & b;
      default: begin
`ifdef ALU_MUL_EN
        v = a * b;
`else
        v = a | b;
`endif
      end
    endcase
    r = 8'(v);
    n = (o == 1) && (a < b);
  endfunction

  // One operand pair with hold_n HOLD cycles between the two LOADs.
  task automatic run_pair(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                          input int hold_n, input logic [7:0] exp_res, input logic exp_neg,
                          input string tag);
    int         lat;
    int         nval;
    logic [7:0] got_res;
    logic       got_neg;
    lat     = -1;
    nval    = 0;
    got_res = 8'h00;
    got_neg = 1'b0;
    src_a   = a;
    src_b   = b;
    op      = o;
    tx      = TX_LOAD;
    for (int t = 1; t <= hold_n + 10; t++) begin
      @(negedge clock);
      if (result_valid) begin
        nval++;
        if (lat < 0) begin
          lat     = t;
          got_res = result;
          got_neg = neg;
        end
      end
      if (t <= hold_n)          tx = TX_HOLD;
      else if (t == hold_n + 1) tx = TX_LOAD;
      else                      tx = TX_NOP;
    end
    check({tag, " latency"}, lat, hold_n + 4);
    check({tag, " pulses"}, nval, 1);
    check({tag, " result"}, int'(got_res), int'(exp_res));
    check({tag, " neg"}, int'(got_neg), int'(exp_neg));
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    int         hold;
    logic [7:0] res;
    logic       neg;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int         nval;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [1:0] ro;
    int         rh;
    logic [7:0] er;
    logic       en;

    errors = 0;
    checks = 0;

    vecs[0] = '{a: 4'd3, b: 4'd5, op: 2'b00, hold: 0, res: 8'h08, neg: 1'b0};
    vecs[1] = '{a: 4'd2, b: 4'd7, op: 2'b01, hold: 0, res: 8'hFB, neg: 1'b1};
    vecs[2] = '{a: 4'd9, b: 4'd4, op: 2'b01, hold: 0, res: 8'h05, neg: 1'b0};
`ifdef ALU_MUL_EN
    vecs[3] = '{a: 4'hF, b: 4'hF, op: 2'b11, hold: 0, res: 8'hE1, neg: 1'b0};
`else
    vecs[3] = '{a: 4'hF, b: 4'hF, op: 2'b11, hold: 0, res: 8'h0F, neg: 1'b0};
`endif
    vecs[4] = '{a: 4'd6, b: 4'd1, op: 2'b00, hold: 3, res: 8'h07, neg: 1'b0};
    vecs[5] = '{a: 4'hA, b: 4'hC, op: 2'b10, hold: 0, res: 8'h08, neg: 1'b0};
    vecs[6] = '{a: 4'hF, b: 4'hF, op: 2'b00, hold: 0, res: 8'h1E, neg: 1'b0};

    reset_n = 1'b0;
    tx      = TX_CLEAR;
    op      = 2'b00;
    src_a   = 4'd0;
    src_b   = 4'd0;
    repeat (2) @(negedge clock);
    check("reset result", int'(result), 0);
    check("reset valid", int'(result_valid), 0);
    check("reset neg", int'(neg), 0);
    check("reset busy", int'(busy), 0);
    reset_n = 1'b1;
    tx      = TX_NOP;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      run_pair(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].hold, vecs[i].res, vecs[i].neg,
               $sformatf("vec%0d", i));
    end

    // CLEAR right after A is captured must drop back to IDLE.
    src_a = 4'd9;
    tx    = TX_LOAD;
    @(negedge clock);
    tx = TX_CLEAR;
    @(negedge clock);
    check("clear busy before", int'(busy), 1);
    tx = TX_NOP;
    @(negedge clock);
    check("clear busy after", int'(busy), 0);
    run_pair(4'd1, 4'd1, 2'b10, 0, 8'h01, 1'b0, "after clear");

    // Asynchronous reset while waiting for B.
    src_a = 4'd5;
    tx    = TX_LOAD;
    @(negedge clock);
    tx = TX_NOP;
    @(negedge clock);
    check("midreset busy before", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset result", int'(result), 0);
    check("midreset valid", int'(result_valid), 0);
    check("midreset neg", int'(neg), 0);
    check("midreset busy", int'(busy), 0);
    @(negedge clock);
    reset_n = 1'b1;
    nval = 0;
    repeat (6) begin
      @(negedge clock);
      if (result_valid) nval++;
    end
    check("midreset no valid", nval, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      ro = 2'($urandom_range(0, 3));
      rh = int'($urandom_range(0, 2));
      ref_alu(int'(ra), int'(rb), int'(ro), er, en);
      run_pair(ra, rb, ro, rh, er, en, $sformatf("rand%0d a=%0h b=%0h op=%0d", i, ra, rb, ro));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
